// File: rtl/paddle_pkg.sv
// Shared types and defaults for the paddle input path.
package paddle_pkg;

    localparam int unsigned X_W           = 10;
    localparam int unsigned DB_CYCLES_DEF = 500000;
    localparam int unsigned MOVE_DIV_DEF  = 250000;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    // Opposing buttons cancel out.
    function automatic dir_t decode_dir(input logic l, input logic r);
        dir_t d;
        d = DIR_NONE;
        if (l && !r) d = DIR_LEFT;
        if (r && !l) d = DIR_RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a counter debouncer; emits the stable
// level and a one-cycle pulse coincident with each accepted 0->1 change.
module button_debouncer
    import paddle_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_W     = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_stable,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 != r_stable) begin
                if (r_cnt == DB_MAX) begin
                    r_stable <= r_sync2;
                    r_rise   <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;

endmodule

// File: rtl/paddle_input_ctrl.sv
// Turns debounced push-buttons into paced, edge-limited paddle move pulses,
// plus a pause toggle and a sticky game-started flag.
module paddle_input_ctrl
    import paddle_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned MOVE_DIV  = MOVE_DIV_DEF,
    parameter int unsigned CNT_W     = 20
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           btn_pause,
    input  logic [X_W-1:0] x_pos,
    input  logic [X_W-1:0] screen_width,
    input  logic [X_W-1:0] paddle_width,
    output logic           move_left,
    output logic           move_right,
    output logic           pause,
    output logic           game_started
);

    localparam logic [CNT_W-1:0] RC_MAX = CNT_W'(MOVE_DIV - 1);

    logic w_dl;
    logic w_dr;
    logic w_pause_rise;
    logic w_unused_rise_l;
    logic w_unused_rise_r;
    logic w_unused_pause_lvl;

    button_debouncer #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_left (
        .clk      (clk),
        .reset    (reset),
        .i_btn    (btn_left),
        .o_stable (w_dl),
        .o_rise   (w_unused_rise_l)
    );

    button_debouncer #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_right (
        .clk      (clk),
        .reset    (reset),
        .i_btn    (btn_right),
        .o_stable (w_dr),
        .o_rise   (w_unused_rise_r)
    );

    button_debouncer #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_pause (
        .clk      (clk),
        .reset    (reset),
        .i_btn    (btn_pause),
        .o_stable (w_unused_pause_lvl),
        .o_rise   (w_pause_rise)
    );

    logic             r_pause;
    logic             r_started;
    logic             r_move_left;
    logic             r_move_right;
    logic [CNT_W-1:0] r_rc;

    dir_t      w_dir;
    logic [10:0] w_x11;
    logic [10:0] w_sw11;
    logic [10:0] w_pw11;
    logic [10:0] w_right_lim;
    logic      w_at_left;
    logic      w_at_right;
    logic      w_run;
    logic      w_rc_zero;
    logic      w_ml_d;
    logic      w_mr_d;

    assign w_dir       = decode_dir(w_dl, w_dr);
    assign w_x11       = {1'b0, x_pos};
    assign w_sw11      = {1'b0, screen_width};
    assign w_pw11      = {1'b0, paddle_width};
    assign w_right_lim = w_sw11 - w_pw11;
    assign w_at_left   = (x_pos == '0);
    // An over-wide paddle has nowhere to go, so treat it as pinned right.
    assign w_at_right  = (w_pw11 >= w_sw11) || (w_x11 >= w_right_lim);
    assign w_run       = (w_dir != DIR_NONE) && !r_pause;
    assign w_rc_zero   = (r_rc == '0);
    assign w_ml_d      = (w_dir == DIR_LEFT) && !r_pause && w_rc_zero && !w_at_left;
    assign w_mr_d      = (w_dir == DIR_RIGHT) && !r_pause && w_rc_zero && !w_at_right;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pause      <= 1'b0;
            r_started    <= 1'b0;
            r_move_left  <= 1'b0;
            r_move_right <= 1'b0;
            r_rc         <= '0;
        end else begin
            r_move_left  <= w_ml_d;
            r_move_right <= w_mr_d;
            r_started    <= r_started | w_ml_d | w_mr_d;
            if (w_pause_rise) begin
                r_pause <= ~r_pause;
            end
            // Cadence keeps running while clamped so leaving an edge stays on beat.
            if (w_run) begin
                r_rc <= (r_rc == RC_MAX) ? '0 : r_rc + CNT_W'(1);
            end else begin
                r_rc <= '0;
            end
        end
    end

    assign move_left    = r_move_left;
    assign move_right   = r_move_right;
    assign pause        = r_pause;
    assign game_started = r_started;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Scoreboard bench for paddle_input_ctrl: a cycle-level behavioural model
// predicts move pulses into a queue that a negedge monitor drains.
module tb_paddle_input_ctrl;
    import paddle_pkg::*;

    localparam int DB = 4;
    localparam int MD = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bl = 1'b0;
    logic       br = 1'b0;
    logic       bp = 1'b0;
    logic [9:0] x  = 10'd100;
    logic [9:0] sw = 10'd640;
    logic [9:0] pw = 10'd80;
    logic       ml;
    logic       mr;
    logic       p;
    logic       gs;

    paddle_input_ctrl #(.DB_CYCLES(DB), .MOVE_DIV(MD), .CNT_W(20)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_left     (bl),
        .btn_right    (br),
        .btn_pause    (bp),
        .x_pos        (x),
        .screen_width (sw),
        .paddle_width (pw),
        .move_left    (ml),
        .move_right   (mr),
        .pause        (p),
        .game_started (gs)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        dir_t dir;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad = 0;
    int  pulse_cnt = 0;

    // Model state: synchronizer pipe, accepted level and mismatch run per button.
    bit  m_s1[3];
    bit  m_s2[3];
    bit  m_stab[3];
    int  m_run[3];
    bit  m_rise;
    bit  m_pause;
    bit  m_started;
    int  m_len;
    int  m_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model, stepped on every rising edge.
    initial begin : model
        bit raw[3];
        bit hl, hr, p_old, rc0, atl, atr, el, er, new_rise;
        int xi, swi, pwi;
        forever begin
            @(posedge clk);
            m_cyc++;
            if (reset) begin
                for (int b = 0; b < 3; b++) begin
                    m_s1[b] = 0; m_s2[b] = 0; m_stab[b] = 0; m_run[b] = 0;
                end
                m_rise = 0; m_pause = 0; m_started = 0; m_len = 0;
            end else begin
                raw[0] = bl; raw[1] = br; raw[2] = bp;
                xi = int'(x); swi = int'(sw); pwi = int'(pw);
                hl    = m_stab[0] && !m_stab[1];
                hr    = m_stab[1] && !m_stab[0];
                p_old = m_pause;
                rc0   = (m_len % MD) == 0;
                atl   = (xi == 0);
                atr   = (pwi >= swi) || (xi >= swi - pwi);
                el    = hl && !p_old && rc0 && !atl;
                er    = hr && !p_old && rc0 && !atr;
                if (el) q.push_back('{cyc: m_cyc, dir: DIR_LEFT});
                if (er) q.push_back('{cyc: m_cyc, dir: DIR_RIGHT});
                if (el || er) m_started = 1;
                m_len = ((hl || hr) && !p_old) ? m_len + 1 : 0;
                if (m_rise) m_pause = !m_pause;
                new_rise = 0;
                for (int b = 0; b < 3; b++) begin
                    if (m_s2[b] != m_stab[b]) begin
                        m_run[b]++;
                        if (m_run[b] == DB) begin
                            m_stab[b] = m_s2[b];
                            m_run[b]  = 0;
                            if (b == 2 && m_stab[b]) new_rise = 1;
                        end
                    end else begin
                        m_run[b] = 0;
                    end
                    m_s2[b] = m_s1[b];
                    m_s1[b] = raw[b];
                end
                m_rise = new_rise;
            end
        end
    end

    // Monitor: matches DUT pulses against the queue and tracks levels.
    initial begin : monitor
        ev_t  e;
        dir_t cur;
        forever begin
            @(negedge clk);
            if (ml || mr) begin
                pulse_cnt++;
                chk("one_hot", int'(ml & mr), 0);
                cur = mr ? DIR_RIGHT : DIR_LEFT;
                if (q.size() == 0) begin
                    chk("unexpected_pulse", int'(cur), int'(DIR_NONE));
                end else begin
                    e = q.pop_front();
                    chk("pulse_cycle", m_cyc, e.cyc);
                    chk("pulse_dir", int'(cur), int'(e.dir));
                end
            end else if (q.size() > 0 && q[0].cyc <= m_cyc) begin
                e = q.pop_front();
                chk("missed_pulse", int'(DIR_NONE), int'(e.dir));
            end
            chk("pause", int'(p), int'(m_pause));
            chk("game_started", int'(gs), int'(m_started));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_pulse(input bit right, output int n);
        int k;
        n = -1;
        k = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            k++;
            if (right ? mr : ml) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic quiet_window(input string name, input int cycles);
        int c0;
        c0 = pulse_cnt;
        tick(cycles);
        chk(name, pulse_cnt - c0, 0);
    endtask

    initial begin : stim
        int n;
        int c0;
        logic [9:0] xs[8];
        xs[0] = 10'd0;   xs[1] = 10'd1;   xs[2] = 10'd300; xs[3] = 10'd558;
        xs[4] = 10'd559; xs[5] = 10'd560; xs[6] = 10'd561; xs[7] = 10'd1023;

        tick(3);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_outputs", int'({ml, mr, p, gs}), 0);

        // Right held from x=100: first pulse latency, then cadence.
        tick(1);
        br = 1'b1;
        wait_pulse(1'b1, n);
        chk("first_right_latency", n, 7);
        chk("started_with_first", int'(gs), 1);
        tick(1);
        c0 = pulse_cnt;
        tick(32);
        chk("right_cadence_count", pulse_cnt - c0, 4);
        br = 1'b0;
        tick(12);

        // Short glitch must be swallowed.
        bl = 1'b1;
        tick(3);
        bl = 1'b0;
        quiet_window("glitch_no_pulse", 15);

        // Edge clamps.
        x = 10'd560;
        br = 1'b1;
        quiet_window("clamp_right", 30);
        br = 1'b0;
        tick(10);
        x = 10'd0;
        bl = 1'b1;
        quiet_window("clamp_left", 30);
        bl = 1'b0;
        tick(10);

        // Both held cancels; releasing right lets left through.
        x = 10'd300;
        bl = 1'b1;
        br = 1'b1;
        quiet_window("both_held", 100);
        br = 1'b0;
        wait_pulse(1'b0, n);
        chk("left_after_release", n, 7);

        // Pause toggling with left still held.
        tick(5);
        bp = 1'b1;
        tick(12);
        chk("pause_on", int'(p), 1);
        quiet_window("paused_no_pulse", 20);
        bp = 1'b0;
        tick(12);
        chk("pause_release_noop", int'(p), 1);
        bp = 1'b1;
        tick(12);
        chk("pause_off", int'(p), 0);
        bp = 1'b0;
        tick(12);

        // Reset mid-hold.
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_mid_hold", int'({ml, mr, p, gs}), 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        wait_pulse(1'b0, n);
        chk("resume_after_reset", n, 7);
        bl = 1'b0;
        tick(12);

        // Randomized segments.
        repeat (150) begin
            bl = 1'($urandom_range(0, 1));
            br = 1'($urandom_range(0, 1));
            bp = ($urandom_range(0, 5) == 0);
            x  = xs[$urandom_range(0, 7)];
            case ($urandom_range(0, 7))
                0: begin sw = 10'd640; pw = 10'd640; end
                1: begin sw = 10'd640; pw = 10'd700; end
                2: begin sw = 10'd100; pw = 10'd20;  end
                default: begin sw = 10'd640; pw = 10'd80; end
            endcase
            reset = ($urandom_range(0, 29) == 0);
            tick($urandom_range(1, 25));
        end

        reset = 1'b0;
        bl = 1'b0;
        br = 1'b0;
        bp = 1'b0;
        tick(20);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
